// File: rtl/mor1kx_store_buffer_combining_if.sv
// rtl/mor1kx_store_buffer_combining_if.sv - LSU store path, bus head and snoop signals of the store buffer
interface mor1kx_store_buffer_combining_if #(
    parameter OPTION_OPERAND_WIDTH = 32,
    parameter DEPTH_WIDTH          = 2
);
    localparam int B = OPTION_OPERAND_WIDTH / 8;

    logic [OPTION_OPERAND_WIDTH-1:0] pc_i;
    logic [OPTION_OPERAND_WIDTH-1:0] adr_i;
    logic [OPTION_OPERAND_WIDTH-1:0] dat_i;
    logic [B-1:0]                    bsel_i;
    logic                            write_i;
    logic [OPTION_OPERAND_WIDTH-1:0] pc_o;
    logic [OPTION_OPERAND_WIDTH-1:0] adr_o;
    logic [OPTION_OPERAND_WIDTH-1:0] dat_o;
    logic [B-1:0]                    bsel_o;
    logic                            read_i;
    logic                            full_o;
    logic                            empty_o;
    logic [DEPTH_WIDTH:0]            count_o;
    logic                            combine_o;
    logic [OPTION_OPERAND_WIDTH-1:0] snoop_adr_i;
    logic                            snoop_hit_o;

    modport master (
        output pc_i, adr_i, dat_i, bsel_i, write_i, read_i, snoop_adr_i,
        input  pc_o, adr_o, dat_o, bsel_o, full_o, empty_o, count_o, combine_o, snoop_hit_o
    );

    modport slave (
        input  pc_i, adr_i, dat_i, bsel_i, write_i, read_i, snoop_adr_i,
        output pc_o, adr_o, dat_o, bsel_o, full_o, empty_o, count_o, combine_o, snoop_hit_o
    );
endinterface

// File: rtl/mor1kx_store_buffer_combining.sv
// rtl/mor1kx_store_buffer_combining.sv - store FIFO with tail write combining and load address snoop
module mor1kx_store_buffer_combining #(
    parameter DEPTH_WIDTH          = 2,
    parameter OPTION_OPERAND_WIDTH = 32,
    parameter FEATURE_COMBINE      = "ENABLED"
) (
    input logic                            clk,
    input logic                            rst,
    mor1kx_store_buffer_combining_if.slave sb
);
    localparam int W       = OPTION_OPERAND_WIDTH;
    localparam int B       = W / 8;
    localparam int OFF     = $clog2(B);
    localparam int ENTRIES = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FULL_COUNT = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] TWO        = (DEPTH_WIDTH+1)'(2);
    localparam bit   COMBINE_EN = (FEATURE_COMBINE == "ENABLED");

    logic [W-1:0]             pc_q   [ENTRIES];
    logic [W-1:0]             adr_q  [ENTRIES];
    logic [W-1:0]             dat_q  [ENTRIES];
    logic [B-1:0]             bsel_q [ENTRIES];
    logic [DEPTH_WIDTH-1:0]   wr_ptr;
    logic [DEPTH_WIDTH-1:0]   rd_ptr;
    logic [DEPTH_WIDTH-1:0]   tail_ptr;
    logic [DEPTH_WIDTH:0]     count;
    logic                     combine;
    logic                     push;
    logic                     pop;
    logic                     snoop_hit;
    logic [DEPTH_WIDTH-1:0]   offset;
    logic                     unused_snoop_low;

    assign tail_ptr = wr_ptr - 1'b1;

    // The head belongs to the bus interface, so merging needs a tail distinct from it.
    assign combine = COMBINE_EN && sb.write_i && (count >= TWO) &&
                     (adr_q[tail_ptr][W-1:OFF] == sb.adr_i[W-1:OFF]);
    assign push    = sb.write_i && !combine && ((count != FULL_COUNT) || sb.read_i);
    assign pop     = sb.read_i && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push) begin
                pc_q[wr_ptr]   <= sb.pc_i;
                adr_q[wr_ptr]  <= sb.adr_i;
                dat_q[wr_ptr]  <= sb.dat_i;
                bsel_q[wr_ptr] <= sb.bsel_i;
            end else if (combine) begin
                pc_q[tail_ptr]   <= sb.pc_i;
                bsel_q[tail_ptr] <= bsel_q[tail_ptr] | sb.bsel_i;
                for (int b = 0; b < B; b++)
                    if (sb.bsel_i[b])
                        dat_q[tail_ptr][8*b +: 8] <= sb.dat_i[8*b +: 8];
            end
        end
    end

    // An entry is occupied when its distance from rd_ptr is below count.
    always_comb begin
        snoop_hit = 1'b0;
        offset    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            offset = DEPTH_WIDTH'(i) - rd_ptr;
            if (({1'b0, offset} < count) &&
                (adr_q[i][W-1:OFF] == sb.snoop_adr_i[W-1:OFF]))
                snoop_hit = 1'b1;
        end
    end

    assign unused_snoop_low = ^sb.snoop_adr_i[OFF-1:0];

    assign sb.pc_o        = pc_q[rd_ptr];
    assign sb.adr_o       = adr_q[rd_ptr];
    assign sb.dat_o       = dat_q[rd_ptr];
    assign sb.bsel_o      = bsel_q[rd_ptr];
    assign sb.count_o     = count;
    assign sb.full_o      = (count == FULL_COUNT);
    assign sb.empty_o     = (count == '0);
    assign sb.combine_o   = combine;
    assign sb.snoop_hit_o = snoop_hit;
endmodule

// File: tb/tb_mor1kx_store_buffer_combining.sv
// tb/tb_mor1kx_store_buffer_combining.sv - vector table, corner sequences and queue-model random checks
module tb_mor1kx_store_buffer_combining;
    localparam int W  = 32;
    localparam int DW = 2;
    localparam int E  = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  bsel;
    } entry_t;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  bsel;
        logic [31:0] pc;
        logic [31:0] snoop;
        int          e_count;
        int          e_ncount;
        bit          e_comb;
        bit          e_hit;
        bit          e_head;
        logic [31:0] e_adr;
        logic [3:0]  e_bsel;
        logic [31:0] e_dat;
        logic [31:0] e_pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mor1kx_store_buffer_combining_if #(.OPTION_OPERAND_WIDTH(W), .DEPTH_WIDTH(DW)) sb ();
    mor1kx_store_buffer_combining_if #(.OPTION_OPERAND_WIDTH(W), .DEPTH_WIDTH(DW)) sbn ();

    assign sbn.pc_i        = sb.pc_i;
    assign sbn.adr_i       = sb.adr_i;
    assign sbn.dat_i       = sb.dat_i;
    assign sbn.bsel_i      = sb.bsel_i;
    assign sbn.write_i     = sb.write_i;
    assign sbn.read_i      = sb.read_i;
    assign sbn.snoop_adr_i = sb.snoop_adr_i;

    mor1kx_store_buffer_combining #(
        .DEPTH_WIDTH(DW), .OPTION_OPERAND_WIDTH(W), .FEATURE_COMBINE("ENABLED")
    ) dut (.clk(clk), .rst(rst), .sb(sb));

    mor1kx_store_buffer_combining #(
        .DEPTH_WIDTH(DW), .OPTION_OPERAND_WIDTH(W), .FEATURE_COMBINE("NONE")
    ) dut_nc (.clk(clk), .rst(rst), .sb(sbn));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit wr, bit rd, logic [31:0] adr, logic [31:0] dat, logic [3:0] bsel,
                                logic [31:0] pc, logic [31:0] snoop, int ec, int enc, bit ecomb,
                                bit ehit, bit ehead, logic [31:0] eadr, logic [3:0] ebsel,
                                logic [31:0] edat, logic [31:0] epc);
        vec_t v;
        v.wr = wr; v.rd = rd; v.adr = adr; v.dat = dat; v.bsel = bsel; v.pc = pc; v.snoop = snoop;
        v.e_count = ec; v.e_ncount = enc; v.e_comb = ecomb; v.e_hit = ehit; v.e_head = ehead;
        v.e_adr = eadr; v.e_bsel = ebsel; v.e_dat = edat; v.e_pc = epc;
        return v;
    endfunction

    // Reference model state: current inputs and one queue per instance, head at index 0.
    bit          cur_rst, cur_wr, cur_rd;
    logic [31:0] cur_adr, cur_dat, cur_pc, cur_snoop;
    logic [3:0]  cur_bsel;
    entry_t      q_en[$];
    entry_t      q_nc[$];

    function automatic bit word_eq(logic [31:0] a, logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    function automatic bit model_comb(input entry_t q[$], input bit en);
        if (!en || !cur_wr || q.size() < 2) return 1'b0;
        return word_eq(q[q.size()-1].adr, cur_adr);
    endfunction

    task automatic model_step(inout entry_t q[$], input bit en);
        entry_t e;
        int     n;
        bit     comb, accept;
        if (cur_rst) begin
            q.delete();
        end else begin
            n      = q.size();
            comb   = model_comb(q, en);
            accept = cur_wr && !comb && (n < E || cur_rd);
            if (comb) begin
                e = q[n-1];
                for (int b = 0; b < 4; b++)
                    if (cur_bsel[b]) e.dat[8*b +: 8] = cur_dat[8*b +: 8];
                e.bsel = e.bsel | cur_bsel;
                e.pc   = cur_pc;
                q[n-1] = e;
            end
            if (cur_rd && n > 0) void'(q.pop_front());
            if (accept) begin
                e.pc = cur_pc; e.adr = cur_adr; e.dat = cur_dat; e.bsel = cur_bsel;
                q.push_back(e);
            end
        end
    endtask

    task automatic check_inst(input string tag, input entry_t q[$], input bit en,
                              input logic [2:0] cnt, input logic full, input logic empty,
                              input logic comb, input logic hit, input logic [31:0] pc,
                              input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] bsel);
        bit exp_hit = 1'b0;
        foreach (q[i]) if (word_eq(q[i].adr, cur_snoop)) exp_hit = 1'b1;
        chk({tag, "_count"}, cnt, q.size());
        chk({tag, "_full"}, full, q.size() == E);
        chk({tag, "_empty"}, empty, q.size() == 0);
        chk({tag, "_combine"}, comb, model_comb(q, en));
        chk({tag, "_snoop"}, hit, exp_hit);
        if (q.size() > 0) begin
            chk({tag, "_head_pc"}, pc, q[0].pc);
            chk({tag, "_head_adr"}, adr, q[0].adr);
            chk({tag, "_head_dat"}, dat, q[0].dat);
            chk({tag, "_head_bsel"}, bsel, q[0].bsel);
        end
    endtask

    task automatic drive(input bit r, input bit wr, input bit rd, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] bsel, input logic [31:0] pc,
                         input logic [31:0] snoop);
        rst = r; sb.write_i = wr; sb.read_i = rd; sb.adr_i = adr; sb.dat_i = dat;
        sb.bsel_i = bsel; sb.pc_i = pc; sb.snoop_adr_i = snoop;
        cur_rst = r; cur_wr = wr; cur_rd = rd; cur_adr = adr; cur_dat = dat;
        cur_bsel = bsel; cur_pc = pc; cur_snoop = snoop;
    endtask

    task automatic model_cycle(input bit r, input bit wr, input bit rd, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] bsel, input logic [31:0] pc,
                               input logic [31:0] snoop);
        drive(r, wr, rd, adr, dat, bsel, pc, snoop);
        #1;
        if (!r) begin
            check_inst("en", q_en, 1'b1, sb.count_o, sb.full_o, sb.empty_o, sb.combine_o,
                       sb.snoop_hit_o, sb.pc_o, sb.adr_o, sb.dat_o, sb.bsel_o);
            check_inst("nc", q_nc, 1'b0, sbn.count_o, sbn.full_o, sbn.empty_o, sbn.combine_o,
                       sbn.snoop_hit_o, sbn.pc_o, sbn.adr_o, sbn.dat_o, sbn.bsel_o);
        end
        @(posedge clk);
        model_step(q_en, 1'b1);
        model_step(q_nc, 1'b0);
        #1;
    endtask

    vec_t vt[$];

    initial begin
        vt.push_back(mk(1,0,'h100,'h11111111,'hF,'h1100,'h100, 0,0,0,0,0, 0,0,0,0));
        vt.push_back(mk(1,0,'h104,'h22222222,'hF,'h1104,'h100, 1,1,0,1,1, 'h100,'hF,'h11111111,'h1100));
        vt.push_back(mk(1,0,'h108,'h33333333,'hF,'h1108,'h108, 2,2,0,0,1, 'h100,'hF,'h11111111,'h1100));
        vt.push_back(mk(1,0,'h10C,'h44444444,'hF,'h110C,'h108, 3,3,0,1,1, 'h100,'hF,'h11111111,'h1100));
        vt.push_back(mk(0,0,0,0,0,0,'h10C,                      4,4,0,1,1, 'h100,'hF,'h11111111,'h1100));
        vt.push_back(mk(1,0,'h110,'h55555555,'hF,'h1110,'h110, 4,4,0,0,1, 'h100,'hF,'h11111111,'h1100));
        vt.push_back(mk(0,1,0,0,0,0,'h110,                      4,4,0,0,1, 'h100,'hF,'h11111111,'h1100));
        vt.push_back(mk(0,1,0,0,0,0,'h100,                      3,3,0,0,1, 'h104,'hF,'h22222222,'h1104));
        vt.push_back(mk(0,1,0,0,0,0,0,                          2,2,0,0,1, 'h108,'hF,'h33333333,'h1108));
        vt.push_back(mk(0,1,0,0,0,0,0,                          1,1,0,0,1, 'h10C,'hF,'h44444444,'h110C));
        vt.push_back(mk(0,1,0,0,0,0,'h10C,                      0,0,0,0,0, 0,0,0,0));
        vt.push_back(mk(1,0,'h120,'h66666666,'hF,'h1120,'h120, 0,0,0,0,0, 0,0,0,0));
        vt.push_back(mk(1,0,'h124,'h77777777,'hF,'h1124,'h120, 1,1,0,1,1, 'h120,'hF,'h66666666,'h1120));
        vt.push_back(mk(1,0,'h128,'h88888888,'hF,'h1128,0,     2,2,0,0,1, 'h120,'hF,'h66666666,'h1120));
        vt.push_back(mk(0,1,0,0,0,0,0,                          3,3,0,0,1, 'h120,'hF,'h66666666,'h1120));
        vt.push_back(mk(0,1,0,0,0,0,0,                          2,2,0,0,1, 'h124,'hF,'h77777777,'h1124));
        vt.push_back(mk(0,1,0,0,0,0,0,                          1,1,0,0,1, 'h128,'hF,'h88888888,'h1128));
        vt.push_back(mk(1,0,'h200,'h000000AA,'h1,'h2000,0,     0,0,0,0,0, 0,0,0,0));
        vt.push_back(mk(1,0,'h300,'h00000011,'h1,'h3000,0,     1,1,0,0,1, 'h200,'h1,'h000000AA,'h2000));
        vt.push_back(mk(1,0,'h300,'h00220000,'h4,'h3004,0,     2,2,1,0,1, 'h200,'h1,'h000000AA,'h2000));
        vt.push_back(mk(0,1,0,0,0,0,0,                          2,3,0,0,1, 'h200,'h1,'h000000AA,'h2000));
        vt.push_back(mk(0,0,0,0,0,0,'h302,                      1,2,0,1,1, 'h300,'h5,'h00220011,'h3004));
        vt.push_back(mk(1,0,'h300,'h00003300,'h2,'h3008,'h302, 1,2,0,1,1, 'h300,'h5,'h00220011,'h3004));
        vt.push_back(mk(0,0,0,0,0,0,'h304,                      2,3,0,0,1, 'h300,'h5,'h00220011,'h3004));
        vt.push_back(mk(1,0,'h400,'h01010101,'hF,'h4000,0,     2,3,0,0,1, 'h300,'h5,'h00220011,'h3004));
        vt.push_back(mk(1,0,'h404,'h02020202,'hF,'h4004,0,     3,4,0,0,1, 'h300,'h5,'h00220011,'h3004));
        vt.push_back(mk(1,0,'h404,'h0000AB00,'h2,'h4008,0,     4,4,1,0,1, 'h300,'h5,'h00220011,'h3004));
        vt.push_back(mk(1,1,'h408,'h03030303,'hF,'h400C,0,     4,4,0,0,1, 'h300,'h5,'h00220011,'h3004));
        vt.push_back(mk(0,1,0,0,0,0,'h408,                      4,4,0,1,1, 'h300,'h2,'h00003300,'h3008));
        vt.push_back(mk(0,1,0,0,0,0,0,                          3,3,0,0,1, 'h400,'hF,'h01010101,'h4000));
        vt.push_back(mk(0,1,0,0,0,0,'h404,                      2,2,0,1,1, 'h404,'hF,'h0202AB02,'h4008));
        vt.push_back(mk(0,1,0,0,0,0,0,                          1,1,0,0,1, 'h408,'hF,'h03030303,'h400C));
        vt.push_back(mk(0,0,0,0,0,0,'h408,                      0,0,0,0,0, 0,0,0,0));

        drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_count", sb.count_o, 0);
        chk("reset_empty", sb.empty_o, 1);
        chk("reset_full", sb.full_o, 0);
        chk("reset_snoop", sb.snoop_hit_o, 0);
        chk("reset_combine", sb.combine_o, 0);
        chk("reset_nc_count", sbn.count_o, 0);

        foreach (vt[i]) begin
            drive(1'b0, vt[i].wr, vt[i].rd, vt[i].adr, vt[i].dat, vt[i].bsel, vt[i].pc, vt[i].snoop);
            #1;
            chk($sformatf("vec%0d_count", i), sb.count_o, vt[i].e_count);
            chk($sformatf("vec%0d_full", i), sb.full_o, vt[i].e_count == E);
            chk($sformatf("vec%0d_empty", i), sb.empty_o, vt[i].e_count == 0);
            chk($sformatf("vec%0d_combine", i), sb.combine_o, vt[i].e_comb);
            chk($sformatf("vec%0d_snoop", i), sb.snoop_hit_o, vt[i].e_hit);
            chk($sformatf("vec%0d_nc_count", i), sbn.count_o, vt[i].e_ncount);
            chk($sformatf("vec%0d_nc_combine", i), sbn.combine_o, 0);
            if (vt[i].e_head) begin
                chk($sformatf("vec%0d_adr", i), sb.adr_o, vt[i].e_adr);
                chk($sformatf("vec%0d_bsel", i), sb.bsel_o, vt[i].e_bsel);
                chk($sformatf("vec%0d_dat", i), sb.dat_o, vt[i].e_dat);
                chk($sformatf("vec%0d_pc", i), sb.pc_o, vt[i].e_pc);
            end
            @(posedge clk);
            #1;
        end

        model_cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            logic [31:0] a, s;
            bit          r, wr, rd;
            a  = 32'h100 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
            s  = 32'h100 + 32'($urandom_range(0, 4)) * 4 + 32'($urandom_range(0, 3));
            r  = ($urandom_range(0, 99) < 2);
            wr = ($urandom_range(0, 99) < 70);
            rd = ($urandom_range(0, 99) < ((c < 300) ? 30 : 65));
            model_cycle(r, wr, rd, a, $urandom, 4'($urandom_range(1, 15)), $urandom, s);
        end

        model_cycle(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        model_cycle(1'b0, 1'b1, 1'b0, 32'h600, 32'hA0A0A0A0, 4'hF, 32'h6000, 32'h600);
        model_cycle(1'b0, 1'b1, 1'b0, 32'h604, 32'hA1A1A1A1, 4'hF, 32'h6004, 32'h600);
        model_cycle(1'b0, 1'b1, 1'b0, 32'h608, 32'hA2A2A2A2, 4'hF, 32'h6008, 32'h604);
        model_cycle(1'b1, 1'b1, 1'b1, 32'h60C, 32'hA3A3A3A3, 4'hF, 32'h600C, 32'h608);
        model_cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 32'h604);
        chk("rst_mid_count", sb.count_o, 0);
        chk("rst_mid_empty", sb.empty_o, 1);
        chk("rst_mid_snoop", sb.snoop_hit_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mor1kx_store_buffer_combining.md
# mor1kx_store_buffer_combining

Parametrised successor store buffer for the mor1kx LSU: a register-based FIFO of 2**DEPTH_WIDTH store entries (address, data, byte select, PC) with optional write combining into the newest entry and an address snoop port for load hazard detection. It sits between the LSU store path and the data bus interface. All entries are usable, with no reserved slot. The head entry is presented first-word-fall-through.

## Interface
- DEPTH_WIDTH, 2, log2 of entry count (ENTRIES = 2**DEPTH_WIDTH)
- OPTION_OPERAND_WIDTH, 32, address/data width W; byte lanes B = W/8
- FEATURE_COMBINE, "ENABLED", "ENABLED" or "NONE"; NONE disables merging entirely

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, sampled on rising clk
- pc_i, adr_i, dat_i  in  W each  store PC, byte address, data
- bsel_i  in  B  byte lane enables
- write_i  in  1  push/merge request
- pc_o, adr_o, dat_o  out  W each  head entry fields
- bsel_o  out  B  head entry byte select
- read_i  in  1  pop head
- full_o  out  1  count == ENTRIES
- empty_o  out  1  count == 0
- count_o  out  DEPTH_WIDTH+1  occupied entries
- combine_o  out  1  current write_i merges (combinational)
- snoop_adr_i  in  W  load address to check
- snoop_hit_o  out  1  some occupied entry matches snoop word address (combinational)

## Operation
- State: entry array, wr_ptr/rd_ptr (DEPTH_WIDTH bits, wrap modulo ENTRIES), count (DEPTH_WIDTH+1 bits). Entry storage not reset.
- Word address = adr[W-1:log2(B)]; all address compares use word address only.
- Tail = entry at wr_ptr-1 (mod ENTRIES).
- combine_o = FEATURE_COMBINE=="ENABLED" && write_i && count>=2 && tail word address == adr_i word address. Head is owned by the bus interface, so it is never merged; count==1 never combines.
- Merge: for each lane with bsel_i set, tail data byte <= dat_i byte; tail bsel <= tail bsel | bsel_i; tail pc <= pc_i; tail adr unchanged; pointers/count unchanged by the write.
- Non-combining write: accepted iff count<ENTRIES or read_i same cycle. Entry written at wr_ptr; wr_ptr+1; count+1.
- Non-combining write while full without read_i: protocol violation; write dropped, state unchanged.
- read_i: when count>0, rd_ptr+1, count-1. When empty, ignored.
- Simultaneous accepted write and read: both pointers advance; count unchanged. Merge plus read with count==2: merge legal (tail is not head); count becomes 1.
- Wrap-around is natural pointer overflow, with no special case.
- Outputs pc_o/adr_o/dat_o/bsel_o = entry[rd_ptr]. Undefined while empty_o=1.
- snoop_hit_o = OR over occupied entries (rd_ptr .. rd_ptr+count-1) of word-address equality with snoop_adr_i. Reflects registered state only; a same-cycle write is not visible.

## Timing
- Reset values: count_o=0, empty_o=1, full_o=0, snoop_hit_o=0, combine_o follows inputs (0 after reset unless count>=2). rst overrides write_i/read_i in the same cycle and discards all entries mid-operation.
- Write at edge N: entry visible on head outputs, count_o, full_o/empty_o and snoop_hit_o after edge N (one-cycle latency into empty buffer).
- read_i at edge N: next entry on outputs after edge N.
- Merge at edge N: merged bytes/bsel/pc visible after edge N. A snoop in the merge cycle sees the pre-merge entry, with the same word address.
- No combinational path from write_i/read_i to head outputs, full_o, empty_o or count_o. combine_o depends combinationally on write_i/adr_i.

## Test plan
- Fill/drain, DEPTH_WIDTH=2: 4 writes adr 0x100,0x104,0x108,0x10C -> full_o=1, count_o=4. 4 reads return in order. Then empty_o=1, and pointers wrap correctly on a further 3 writes.
- Combine: writes 0x200 bsel 0001 dat 0xAA, 0x300 bsel 0001 dat 0x11, 0x300 bsel 0100 dat 0x00220000 -> combine_o=1 on third. count_o=2. Second pop gives adr 0x300, bsel 0101, dat byte0=0x11, byte2=0x22, pc of third write.
- No head merge: count=1 at 0x400, write 0x400 -> combine_o=0, count_o=2. With FEATURE_COMBINE="NONE", same-address writes always allocate.
- Full boundary: full, write without read -> dropped, count_o stays 4. Full, write+read same cycle -> accepted, count_o=4, order preserved. Full, combinable write -> merged.
- Snoop: entries 0x500, 0x504. snoop_adr_i 0x506 -> hit=1. 0x508 -> 0. Pop both -> 0x504 no longer hits.
- Reset mid-operation: rst with 3 entries plus write_i/read_i asserted -> next cycle empty_o=1, count_o=0, snoop_hit_o=0.
